// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared encodings for the data-memory controller
// Rev 1.0
// ============================================================================
package mem_pkg;

   // funct3 load/store sizes; bit 2 marks an unsigned load
   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   localparam int DATA_W     = 32;
   localparam int BE_W       = DATA_W / 8;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
// mem_lane_align : byte-lane steering, load extension and alignment check
// Rev 1.0
// ============================================================================
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]        addr_lo_i,
   input  logic [2:0]        size_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rword_i,
   output logic [DATA_W-1:0] wdata_o,
   output logic [BE_W-1:0]   be_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              misaligned_o
);

   logic [DATA_W-1:0] w_shift;

   always_comb begin
      w_shift      = rword_i >> {addr_lo_i, 3'b000};
      wdata_o      = wdata_i;
      be_o         = '0;
      rdata_o      = '0;
      misaligned_o = 1'b0;

      case (size_i[1:0])
         MEM_B[1:0]: begin
            wdata_o = {4{wdata_i[7:0]}};
            be_o    = 4'b0001 << addr_lo_i;
            rdata_o = size_i[2] ? {24'b0, w_shift[7:0]}
                                : {{24{w_shift[7]}}, w_shift[7:0]};
         end
         MEM_H[1:0]: begin
            misaligned_o = addr_lo_i[0];
            wdata_o      = {2{wdata_i[15:0]}};
            be_o         = 4'b0011 << addr_lo_i;
            rdata_o      = size_i[2] ? {16'b0, w_shift[15:0]}
                                     : {{16{w_shift[15]}}, w_shift[15:0]};
         end
         MEM_W[1:0]: begin
            misaligned_o = |addr_lo_i;
            be_o         = 4'hF;
            rdata_o      = rword_i;
         end
         default: misaligned_o = 1'b1;
      endcase

      // A faulting access must neither write nor return data
      if (misaligned_o) begin
         be_o    = '0;
         rdata_o = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// data_mem_ctrl : req/ack data memory with wait states and tohost halt register
// Rev 1.0
// ============================================================================
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DEPTH_WORDS = 256,
   parameter int                    WAIT_STATES = 0,
   parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'hFFFF_FFF0
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [2:0]            size_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  ack_o,
   output logic                  misaligned_o,
   output logic                  halt_o,
   output logic [DATA_W-1:0]     tohost_o
);

   localparam int                    IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] C_WAIT = WAIT_CNT_W'(WAIT_STATES);

   state_e                  state_q, state_d;
   logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
   logic                    ack_q, ack_d;
   logic                    latch_en;

   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [2:0]              size_q;
   logic [DATA_W-1:0]       wdata_q;

   logic [DATA_W-1:0]       rdata_q;
   logic                    mis_q;
   logic                    halt_q;
   logic [DATA_W-1:0]       tohost_q;

   logic [DATA_W-1:0]       mem_q [DEPTH_WORDS];

   logic                    w_access;
   logic                    w_hit_tohost;
   logic [IDX_W-1:0]        w_idx;
   logic [DATA_W-1:0]       w_rword;
   logic [DATA_W-1:0]       w_wdata_rep;
   logic [BE_W-1:0]         w_be;
   logic [DATA_W-1:0]       w_rdata_ext;
   logic                    w_mis;
   logic                    w_wr;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      latch_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The ack cycle blocks re-acceptance of a still-held req
            if (req_i && !ack_q) begin
               latch_en = 1'b1;
               cnt_d    = C_WAIT;
               state_d  = (C_WAIT != '0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == WAIT_CNT_W'(1)) state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            ack_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------- datapath
   assign w_access     = (state_q == ST_ACCESS);
   assign w_hit_tohost = (addr_q[ADDR_WIDTH-1:2] == TOHOST_ADDR[ADDR_WIDTH-1:2]);
   assign w_idx        = addr_q[2 +: IDX_W];
   assign w_rword      = w_hit_tohost ? tohost_q : mem_q[w_idx];
   assign w_wr         = w_access && we_q && !w_mis;

   mem_lane_align u_align (
      .addr_lo_i    (addr_q[1:0]),
      .size_i       (size_q),
      .wdata_i      (wdata_q),
      .rword_i      (w_rword),
      .wdata_o      (w_wdata_rep),
      .be_o         (w_be),
      .rdata_o      (w_rdata_ext),
      .misaligned_o (w_mis)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         mis_q    <= 1'b0;
         halt_q   <= 1'b0;
         tohost_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         if (latch_en) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            size_q  <= size_i;
            wdata_q <= wdata_i;
         end
         // Store completions leave rdata untouched unless they fault
         if (w_access) begin
            mis_q <= w_mis;
            if (w_mis)      rdata_q <= '0;
            else if (!we_q) rdata_q <= w_rdata_ext;
         end
         if (w_wr && w_hit_tohost) begin
            halt_q <= 1'b1;
            for (int i = 0; i < BE_W; i++) begin
               if (w_be[i]) tohost_q[8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
         end
      end
   end

   // Array has no reset; a reset forces IDLE so a pending write never lands
   always_ff @(posedge clk) begin
      if (w_wr && !w_hit_tohost) begin
         for (int i = 0; i < BE_W; i++) begin
            if (w_be[i]) mem_q[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
         end
      end
   end

   assign rdata_o      = rdata_q;
   assign ack_o        = ack_q;
   assign misaligned_o = mis_q;
   assign halt_o       = halt_q;
   assign tohost_o     = tohost_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_data_mem_ctrl : scoreboard bench, zero-wait and three-wait instances
// Rev 1.0
// ============================================================================
module tb_data_mem_ctrl;
   import mem_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0_n, rst3_n, req0, req3, we_s;
   logic [31:0] addr_s, wdata_s;
   logic [2:0]  size_s;
   logic [31:0] rdata0, tohost0, rdata3, tohost3;
   logic        ack0, mis0, halt0, ack3, mis3, halt3;

   data_mem_ctrl #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst0_n), .req_i(req0), .we_i(we_s), .addr_i(addr_s),
      .size_i(size_s), .wdata_i(wdata_s), .rdata_o(rdata0), .ack_o(ack0),
      .misaligned_o(mis0), .halt_o(halt0), .tohost_o(tohost0));

   data_mem_ctrl #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .req_i(req3), .we_i(we_s), .addr_i(addr_s),
      .size_i(size_s), .wdata_i(wdata_s), .rdata_o(rdata3), .ack_o(ack3),
      .misaligned_o(mis3), .halt_o(halt3), .tohost_o(tohost3));

   // Expected response: {check_rdata, rdata, misaligned}
   logic [33:0] q0[$];
   logic [33:0] q3[$];
   logic [33:0] e0, e3;
   int checks   = 0;
   int failures = 0;

   always @(negedge clk) begin
      if (ack0) begin
         checks++;
         if (q0.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack0 rdata=%h", rdata0);
         end else begin
            e0 = q0.pop_front();
            if (mis0 !== e0[0] || (e0[33] && rdata0 !== e0[32:1])) begin
               failures++;
               $display("FAIL resp0 got rdata=%h mis=%b want rdata=%h mis=%b",
                        rdata0, mis0, e0[32:1], e0[0]);
            end
         end
      end
      if (ack3) begin
         checks++;
         if (q3.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack3 rdata=%h", rdata3);
         end else begin
            e3 = q3.pop_front();
            if (mis3 !== e3[0] || (e3[33] && rdata3 !== e3[32:1])) begin
               failures++;
               $display("FAIL resp3 got rdata=%h mis=%b want rdata=%h mis=%b",
                        rdata3, mis3, e3[32:1], e3[0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   function automatic logic [33:0] exp_of(input bit chk, input logic [31:0] rd, input bit mis);
      return {chk, rd, mis};
   endfunction

   task automatic push_exp(input bit sel, input logic [33:0] e);
      if (sel) q3.push_back(e);
      else     q0.push_back(e);
   endtask

   task automatic wait_ack(input bit sel, input string name, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      while (!got && lat < 60) begin
         @(negedge clk);
         lat++;
         got = sel ? ack3 : ack0;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout got=no_ack want=ack", name);
         if (sel) void'(q3.pop_back());
         else     void'(q0.pop_back());
      end
   endtask

   // Starts at a negedge with the addressed DUT idle and ack low.
   // chk=0 skips the rdata compare (successful stores leave rdata unspecified).
   task automatic access(input bit sel, input bit we, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input bit chk, input logic [31:0] er, input bit em,
                         input bit hold);
      int lat;
      int lat_exp;
      lat_exp = sel ? 5 : 2;
      push_exp(sel, exp_of(chk, er, em));
      we_s = we; addr_s = a; size_s = sz; wdata_s = wd;
      if (sel) req3 = 1'b1; else req0 = 1'b1;
      wait_ack(sel, "access", lat);
      check("ack_latency", 32'(lat), 32'(lat_exp));
      if (hold) begin
         // req still high: ignored during ack, accepted on the following edge
         push_exp(sel, exp_of(chk, er, em));
         @(negedge clk);
         check("ack_width_hold", 32'(sel ? ack3 : ack0), 32'd0);
         wait_ack(sel, "reaccept", lat);
         check("reaccept_latency", 32'(lat), 32'(lat_exp));
      end
      req0 = 1'b0;
      req3 = 1'b0;
      @(negedge clk);
      check("ack_width", 32'(sel ? ack3 : ack0), 32'd0);
   endtask

   int lat_m;

   initial begin
      rst0_n = 1'b0; rst3_n = 1'b0; req0 = 1'b0; req3 = 1'b0;
      we_s = 1'b0; addr_s = '0; size_s = MEM_W; wdata_s = '0;
      repeat (3) @(negedge clk);
      rst0_n = 1'b1; rst3_n = 1'b1;
      @(negedge clk);

      check("rst_rdata",  rdata0,         32'h0);
      check("rst_ack",    32'(ack0),      32'h0);
      check("rst_mis",    32'(mis0),      32'h0);
      check("rst_halt",   32'(halt0),     32'h0);
      check("rst_tohost", tohost0,        32'h0);

      // Word store/load
      access(0, 1, 32'h10, MEM_W, 32'hDEADBEEF, 0, 32'h0,        0, 0);
      access(0, 0, 32'h10, MEM_W, 32'h0,        1, 32'hDEADBEEF, 0, 0);
      // Byte store, sign/zero extension, halfword extension
      access(0, 1, 32'h11, MEM_B,  32'h80, 0, 32'h0,        0, 0);
      access(0, 0, 32'h11, MEM_B,  32'h0,  1, 32'hFFFFFF80, 0, 0);
      access(0, 0, 32'h11, MEM_BU, 32'h0,  1, 32'h00000080, 0, 0);
      access(0, 0, 32'h10, MEM_W,  32'h0,  1, 32'hDEAD80EF, 0, 0);
      access(0, 0, 32'h12, MEM_H,  32'h0,  1, 32'hFFFFDEAD, 0, 0);
      access(0, 0, 32'h12, MEM_HU, 32'h0,  1, 32'h0000DEAD, 0, 0);
      // Misalignment faults
      access(0, 0, 32'h13, MEM_H,  32'h0, 1, 32'h0, 1, 0);
      access(0, 1, 32'h12, MEM_W,  32'h5, 1, 32'h0, 1, 0);
      access(0, 0, 32'h10, 3'b011, 32'h0, 1, 32'h0, 1, 0);
      access(0, 0, 32'h10, MEM_W,  32'h0, 1, 32'hDEAD80EF, 0, 0);
      access(0, 1, 32'h12, MEM_H,  32'h1234, 0, 32'h0, 0, 0);
      access(0, 0, 32'h10, MEM_W,  32'h0, 1, 32'h123480EF, 0, 0);

      // tohost: shares index bits with 0x3F0 but must not touch the array
      access(0, 1, 32'h3F0, MEM_W, 32'h55AA55AA, 0, 32'h0, 0, 0);
      check("halt_before", 32'(halt0), 32'h0);
      access(0, 1, 32'hFFFF_FFF0, MEM_W, 32'h1, 0, 32'h0, 0, 0);
      check("halt_set",  32'(halt0), 32'h1);
      check("tohost_sw", tohost0,    32'h1);
      access(0, 0, 32'h3F0,       MEM_W, 32'h0, 1, 32'h55AA55AA, 0, 0);
      access(0, 0, 32'hFFFF_FFF0, MEM_W, 32'h0, 1, 32'h1,        0, 0);
      access(0, 1, 32'hFFFF_FFF1, MEM_B, 32'hA5, 0, 32'h0, 0, 0);
      check("tohost_sb", tohost0, 32'h0000A501);
      access(0, 0, 32'h10, MEM_W, 32'h0, 1, 32'h123480EF, 0, 0);
      check("halt_sticky", 32'(halt0), 32'h1);

      // Address wrap modulo 256 words
      access(0, 1, 32'h400, MEM_W, 32'h1234, 0, 32'h0,    0, 0);
      access(0, 0, 32'h0,   MEM_W, 32'h0,    1, 32'h1234, 0, 0);

      // Three wait states, then a held req re-accepted after the ack cycle
      access(1, 1, 32'h20, MEM_W, 32'hAB, 0, 32'h0,  0, 0);
      access(1, 0, 32'h20, MEM_W, 32'h0,  1, 32'hAB, 0, 1);

      // Reset during WAIT drops the store
      we_s = 1'b1; addr_s = 32'h20; size_s = MEM_W; wdata_s = 32'hFF; req3 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst3_n = 1'b0;
      #1;
      check("rst_wait_ack", 32'(ack3), 32'h0);
      req3 = 1'b0;
      @(negedge clk);
      rst3_n = 1'b1;
      @(negedge clk);
      access(1, 0, 32'h20, MEM_W, 32'h0, 1, 32'hAB, 0, 0);

      // Reset during the ack cycle clears ack and rdata at once
      push_exp(1, exp_of(1, 32'hAB, 0));
      we_s = 1'b0; addr_s = 32'h20; size_s = MEM_W; req3 = 1'b1;
      wait_ack(1, "rst_ack_phase", lat_m);
      req3 = 1'b0;
      rst3_n = 1'b0;
      #1;
      check("rst_ack_clr",   32'(ack3), 32'h0);
      check("rst_rdata_clr", rdata3,    32'h0);
      @(negedge clk);
      rst3_n = 1'b1;
      repeat (2) @(negedge clk);

      check("q0_drained", 32'(q0.size()), 32'h0);
      check("q3_drained", 32'(q3.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
